kds_ctrl: RTL and testbench

Sequencing controller for the 12-lane kernel data shifter (three FIFO-backed value lanes per line element).
- Accepts a valid/ready stream of pixel-triplet beats and produces the one-hot line-element load select (LE_select) and the global shift strobe (cycle_enable).
- Primes the shifter, then presents a window-valid handshake to the downstream PE array while traversing the feature map row by row.
- Sits between the input streamer and the shifter datapath; the datapath itself is not part of this block.

---
 rtl/kds_ctrl.sv | 128 ++++++++++++
 tb/tb_kds_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kds_ctrl.sv
// kds_ctrl: sequencing controller for the kernel data shifter.
// Accepts a valid/ready stream of pixel-triplet beats, loads line elements one at a time through
// a one-hot select, primes the shifter with NUM_LE beats, then offers a window handshake to the
// PE array while walking the feature map row by row.
//
// Ports:
//   clk, arst_in       clock; asynchronous active-high reset
//   start              frame start request, sampled only while idle
//   in_valid/in_ready  upstream beat handshake (fire = in_valid & in_ready)
//   LE_select          one-hot line-element load select, zero when no beat fires
//   cycle_enable       shifter advance strobe, high exactly on a fire
//   win_valid/ready    window handshake towards the PE array
//   busy, done         activity flag; one-cycle end-of-frame pulse
//   row_idx, col_idx   position of the next beat in the frame
module kds_ctrl #(
  parameter int unsigned NUM_LE        = 12,
  parameter int unsigned BEATS_PER_ROW = 1024,
  parameter int unsigned ROWS          = 1024,
  parameter int unsigned CNT_W         = 10
) (
  input  logic              clk,
  input  logic              arst_in,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NUM_LE-1:0] LE_select,
  output logic              cycle_enable,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  row_idx,
  output logic [CNT_W-1:0]  col_idx
);

  localparam int unsigned PtrW = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(NUM_LE - 1);
  localparam logic [CNT_W-1:0] ColLast = CNT_W'(BEATS_PER_ROW - 1);
  localparam logic [CNT_W-1:0] RowLast = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  le_ptr_q, le_ptr_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             fire;

  always_comb begin
    state_d      = state_q;
    le_ptr_d     = le_ptr_q;
    row_d        = row_q;
    col_d        = col_q;
    in_ready     = 1'b0;
    win_valid    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    fire         = 1'b0;
    LE_select    = '0;
    cycle_enable = 1'b0;

    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d  = StPrime;
          le_ptr_d = '0;
          row_d    = '0;
          col_d    = '0;
        end
      end
      StPrime: in_ready = 1'b1;
      StRun: begin
        in_ready  = win_ready;
        win_valid = in_valid;
      end
      StDone: begin
        done     = 1'b1;
        state_d  = StIdle;
        le_ptr_d = '0;
        row_d    = '0;
        col_d    = '0;
      end
      default: state_d = StIdle;
    endcase

    // in_ready is zero outside PRIME/RUN, so a fire can only happen there.
    fire         = in_valid & in_ready;
    cycle_enable = fire;
    if (fire) begin
      LE_select[le_ptr_q] = 1'b1;
      le_ptr_d = (le_ptr_q == PtrLast) ? '0 : le_ptr_q + 1'b1;
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Frame end wins over the prime->run hand-off so short frames finish from PRIME.
      if (row_q == RowLast && col_q == ColLast) begin
        state_d  = StDone;
        le_ptr_d = '0;
        row_d    = '0;
        col_d    = '0;
      end else if (state_q == StPrime && le_ptr_q == PtrLast) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q  <= StIdle;
      le_ptr_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      le_ptr_q <= le_ptr_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign row_idx = row_q;
  assign col_idx = col_q;

endmodule

// File: tb/tb_kds_ctrl.sv
// Bench for kds_ctrl: three instances (small 4x3x2 frame, full-size 12x1024x1024 frame, and a
// frame shorter than the prime depth). Stimulus pushes the expected beat sequence, derived from
// the beat number alone, into a per-instance queue; a negedge monitor pops one entry per
// observed cycle_enable and also runs a cycle-level frame model for the handshake outputs.
module tb_kds_ctrl;

  localparam int N = 3;

  function automatic int unsigned p_le(input int i);
    return (i == 1) ? 12 : 4;
  endfunction
  function automatic int unsigned p_bpr(input int i);
    return (i == 1) ? 1024 : 3;
  endfunction
  function automatic int unsigned p_rows(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1024 : 1);
  endfunction

  typedef struct packed {
    logic [11:0] le;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        wv;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst      [N];
  logic        start     [N];
  logic        in_valid  [N];
  logic        win_ready [N];
  logic        in_ready  [N];
  logic        cyc_en    [N];
  logic        win_valid [N];
  logic        busy      [N];
  logic        done      [N];
  logic [11:0] le_sel    [N];
  logic [9:0]  row_idx   [N];
  logic [9:0]  col_idx   [N];

  rec_t exp_q [N][$];
  int   checks = 0;
  int   errors = 0;
  int   mst [N];  // model phase: 0 idle, 1 in frame, 2 end-of-frame cycle
  int   mk  [N];  // model: beats fired so far in the current frame

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned NL = p_le(g);
    logic [NL-1:0] le_w;
    kds_ctrl #(
      .NUM_LE       (NL),
      .BEATS_PER_ROW(p_bpr(g)),
      .ROWS         (p_rows(g)),
      .CNT_W        (10)
    ) u_dut (
      .clk         (clk),
      .arst_in     (arst[g]),
      .start       (start[g]),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .LE_select   (le_w),
      .cycle_enable(cyc_en[g]),
      .win_valid   (win_valid[g]),
      .win_ready   (win_ready[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .row_idx     (row_idx[g]),
      .col_idx     (col_idx[g])
    );
    assign le_sel[g] = 12'(le_w);
  end

  task automatic chk(input int i, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, i, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int   nl, bpr, tot;
      logic eir, efire, ewv;
      rec_t r;
      nl  = int'(p_le(i));
      bpr = int'(p_bpr(i));
      tot = bpr * int'(p_rows(i));
      if (arst[i]) begin
        chk(i, "reset_outs", 64'({in_ready[i], cyc_en[i], win_valid[i], busy[i], done[i],
                                  le_sel[i], row_idx[i], col_idx[i]}), 64'(0));
        mst[i] = 0;
        mk[i]  = 0;
      end else begin
        eir   = (mst[i] == 1) && ((mk[i] < nl) || win_ready[i]);
        efire = in_valid[i] & eir;
        ewv   = (mst[i] == 1) && (mk[i] >= nl) && in_valid[i];
        chk(i, "ctl", 64'({in_ready[i], cyc_en[i], win_valid[i], busy[i], done[i]}),
            64'({eir, efire, ewv, mst[i] != 0, mst[i] == 2}));
        if (mst[i] == 1)
          chk(i, "idx", 64'({row_idx[i], col_idx[i]}), 64'({10'(mk[i] / bpr), 10'(mk[i] % bpr)}));
        else if (mst[i] == 0)
          chk(i, "idx_idle", 64'({row_idx[i], col_idx[i]}), 64'(0));
        if (cyc_en[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(i, "unexpected_beat", 64'(le_sel[i]), 64'(0));
          end else begin
            r = exp_q[i].pop_front();
            chk(i, "beat", 64'({le_sel[i], row_idx[i], col_idx[i], win_valid[i]}), 64'(r));
          end
        end else begin
          chk(i, "le_quiet", 64'(le_sel[i]), 64'(0));
        end
        if (mst[i] == 0) begin
          if (start[i]) begin
            mst[i] = 1;
            mk[i]  = 0;
          end
        end else if (mst[i] == 1) begin
          if (efire) begin
            if (mk[i] == tot - 1) begin
              mst[i] = 2;
              mk[i]  = 0;
            end else begin
              mk[i]++;
            end
          end
        end else begin
          mst[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input int i, input int n);
    int nl, bpr;
    rec_t r;
    nl  = int'(p_le(i));
    bpr = int'(p_bpr(i));
    exp_q[i].delete();
    for (int k = 0; k < n; k++) begin
      r.le  = 12'(1) << (k % nl);
      r.row = 10'(k / bpr);
      r.col = 10'(k % bpr);
      r.wv  = (k >= nl);
      exp_q[i].push_back(r);
    end
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  // mode 0: always valid/ready; 1: in_valid toggles; 2: random on both sides.
  task automatic run(input int i, input int mode, input int stop_at, input int budget);
    int   cyc;
    logic tog;
    cyc = 0;
    tog = 1'b1;
    while (exp_q[i].size() > stop_at && cyc < budget) begin
      case (mode)
        0: begin in_valid[i] = 1'b1; win_ready[i] = 1'b1; end
        1: begin in_valid[i] = tog;  win_ready[i] = 1'b1; tog = ~tog; end
        default: begin
          in_valid[i]  = ($urandom_range(3) != 0);
          win_ready[i] = ($urandom_range(3) != 0);
        end
      endcase
      tick();
      cyc++;
    end
    checks++;
    if (exp_q[i].size() > stop_at) begin
      errors++;
      $display("FAIL run_timeout inst=%0d pending=%0d required=%0d", i, exp_q[i].size(), stop_at);
    end
    in_valid[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      arst[i] = 1'b1; start[i] = 1'b0; in_valid[i] = 1'b0; win_ready[i] = 1'b0;
      mst[i] = 0; mk[i] = 0;
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) arst[i] = 1'b0;
    tick();

    // Small frame, streaming; start during the end-of-frame cycle must be ignored.
    begin_frame(0, 6);
    run(0, 0, 0, 40);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();

    // Bubbles in PRIME and RUN.
    begin_frame(0, 6);
    run(0, 1, 0, 40);
    repeat (2) tick();

    // Five-cycle downstream stall in RUN.
    begin_frame(0, 6);
    run(0, 0, 2, 40);
    in_valid[0]  = 1'b1;
    win_ready[0] = 1'b0;
    repeat (5) tick();
    run(0, 0, 0, 40);
    repeat (2) tick();

    // Random back-pressure on both sides.
    repeat (4) begin
      begin_frame(0, 6);
      run(0, 2, 0, 200);
      repeat (2) tick();
    end

    // Frame shorter than the prime depth finishes from PRIME.
    begin_frame(2, 3);
    run(2, 0, 0, 40);
    repeat (3) tick();

    // Full-size geometry: row wrap, start while busy, reset mid-RUN at row 1 col 1.
    begin_frame(1, 1040);
    run(1, 2, 15, 8000);
    start[1] = 1'b1;
    tick();
    start[1]     = 1'b0;
    in_valid[1]  = 1'b1;
    win_ready[1] = 1'b0;
    #1;
    arst[1] = 1'b1;
    exp_q[1].delete();
    tick();
    tick();
    arst[1]      = 1'b0;
    in_valid[1]  = 1'b0;
    tick();
    begin_frame(1, 14);
    run(1, 0, 0, 60);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
